ze_9: RTL and testbench



---
 rtl/ze_9.sv | 109 ++++++++++
 tb/tb_ze_9.sv | 154 +++++++++++++++
 2 files changed

// File: rtl/ze_9.sv
// ze_9: zero-extension unit for IN_W-bit immediates, with a combinational result and a
// registered result behind a 2-entry skid buffer. Define ZE_9_SIGN_EXT_EN to add a `sext` input.
module ze_9 #(
    parameter int IN_W  = 12,
    parameter int OUT_W = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IN_W-1:0]  in,
    input  logic             in_valid,
    output logic             in_ready,
`ifdef ZE_9_SIGN_EXT_EN
    input  logic             sext,
`endif
    output logic [OUT_W-1:0] out,
    output logic [OUT_W-1:0] out_q,
    output logic             out_valid,
    input  logic             out_ready
);

    generate
        if (IN_W < 1 || IN_W > OUT_W) begin : g_bad_width
            $error("ze_9: IN_W must be in the range 1..OUT_W");
        end
    endgenerate

    // Fill every bit first, then overlay the field; this also covers IN_W == OUT_W.
    function automatic logic [OUT_W-1:0] extend(input logic [IN_W-1:0] v, input logic sx);
        logic [OUT_W-1:0] r;
        r = {OUT_W{sx & v[IN_W-1]}};
        r[IN_W-1:0] = v;
        return r;
    endfunction

    logic             sext_s;
    logic [OUT_W-1:0] ext_s;
    logic             accept_s;
    logic             pop_s;

`ifdef ZE_9_SIGN_EXT_EN
    assign sext_s = sext;
`else
    assign sext_s = 1'b0;
`endif

    assign ext_s = extend(in, sext_s);
    assign out   = ext_s;

    logic             main_valid_q, main_valid_d;
    logic [OUT_W-1:0] main_data_q,  main_data_d;
    logic             skid_valid_q, skid_valid_d;
    logic [OUT_W-1:0] skid_data_q,  skid_data_d;

    assign in_ready  = ~skid_valid_q;
    assign out_valid = main_valid_q;
    assign out_q     = main_data_q;

    assign accept_s = in_valid & in_ready;
    assign pop_s    = main_valid_q & out_ready;

    // Buffer next-state: main is the head of the queue, skid is the second entry.
    always_comb begin
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;
        if (!main_valid_q) begin
            if (accept_s) begin
                main_valid_d = 1'b1;
                main_data_d  = ext_s;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (pop_s) begin
            if (skid_valid_q) begin
                // in_ready is low here, so nothing new can arrive this cycle.
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end else if (accept_s) begin
                main_data_d  = ext_s;
            end else begin
                main_valid_d = 1'b0;
            end
        end else begin
            if (accept_s) begin
                skid_valid_d = 1'b1;
                skid_data_d  = ext_s;
            end else begin
                skid_valid_d = skid_valid_q;
            end
        end
    end

    // State registers; data keeps its last value when invalidated so out_q holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_valid_q <= 1'b0;
            main_data_q  <= {OUT_W{1'b0}};
            skid_valid_q <= 1'b0;
            skid_data_q  <= {OUT_W{1'b0}};
        end else begin
            main_valid_q <= main_valid_d;
            main_data_q  <= main_data_d;
            skid_valid_q <= skid_valid_d;
            skid_data_q  <= skid_data_d;
        end
    end

endmodule

// File: tb/tb_ze_9.sv
// Randomized bench for ze_9 against a queue-based reference of the 2-entry buffer.
module tb_ze_9;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] imm;
    logic        imm_valid;
    logic        imm_ready;
    logic [63:0] ext_comb;
    logic [63:0] ext_q;
    logic        ext_valid;
    logic        ext_ready;
`ifdef ZE_9_SIGN_EXT_EN
    logic        sx;
`endif

    logic [63:0] exp_q[$];
    logic [63:0] last_out;
    int          n_cmp = 0;
    int          n_err = 0;

    always #5 clk = ~clk;

    ze_9 #(.IN_W(12), .OUT_W(64)) dut (
        .clk      (clk),
        .reset    (rst),
        .in       (imm),
        .in_valid (imm_valid),
        .in_ready (imm_ready),
`ifdef ZE_9_SIGN_EXT_EN
        .sext     (sx),
`endif
        .out      (ext_comb),
        .out_q    (ext_q),
        .out_valid(ext_valid),
        .out_ready(ext_ready)
    );

    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] ref_ext(input logic [11:0] v, input logic s);
        if (s) return 64'($signed(v));
        else   return 64'(v);
    endfunction

    // One clock: drive at negedge, check comb output, update model at posedge, check state.
    task automatic step(input logic r, input logic [11:0] v, input logic vv,
                        input logic rdy, input logic s);
        logic acc;
        logic pop;
        logic s_eff;
`ifdef ZE_9_SIGN_EXT_EN
        s_eff = s;
        sx    = s;
`else
        s_eff = 1'b0 & s;
`endif
        rst       = r;
        imm       = v;
        imm_valid = vv;
        ext_ready = rdy;
        #1;
        chk_eq("out_comb", ext_comb, ref_ext(v, s_eff));
        acc = !r && vv && (exp_q.size() < 2);
        pop = !r && (exp_q.size() > 0) && rdy;
        @(posedge clk);
        if (r) begin
            exp_q.delete();
            last_out = 64'h0;
        end else begin
            if (pop) last_out = exp_q.pop_front();
            if (acc) exp_q.push_back(ref_ext(v, s_eff));
        end
        @(negedge clk);
        chk_eq("out_valid", 64'(ext_valid), 64'(exp_q.size() > 0));
        chk_eq("in_ready", 64'(imm_ready), 64'(exp_q.size() < 2));
        chk_eq("out_q", ext_q, (exp_q.size() > 0) ? exp_q[0] : last_out);
    endtask

    initial begin
        rst = 1'b1; imm = 12'h0; imm_valid = 1'b0; ext_ready = 1'b0;
        last_out = 64'h0;
`ifdef ZE_9_SIGN_EXT_EN
        sx = 1'b0;
`endif
        @(negedge clk);

        // Reset for two cycles, then idle.
        step(1'b1, 12'h0, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h0, 1'b0, 1'b0, 1'b0);
        chk_eq("rst_out_q", ext_q, 64'h0);
        chk_eq("rst_out_valid", 64'(ext_valid), 64'h0);
        chk_eq("rst_in_ready", 64'(imm_ready), 64'h1);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
        chk_eq("idle_out", ext_comb, 64'h0);

        // Single transfer and in-order pair.
        step(1'b0, 12'h1FC, 1'b1, 1'b1, 1'b0);
        chk_eq("imm_1fc_q", ext_q, 64'h00000000000001FC);
        step(1'b0, 12'h002, 1'b1, 1'b1, 1'b0);
        chk_eq("imm_002_q", ext_q, 64'h2);
        step(1'b0, 12'hFFF, 1'b1, 1'b1, 1'b0);
        chk_eq("imm_fff_q", ext_q, 64'h0000000000000FFF);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);

        // Backpressure: third value must be refused.
        step(1'b0, 12'h123, 1'b1, 1'b0, 1'b0);
        step(1'b0, 12'h456, 1'b1, 1'b0, 1'b0);
        chk_eq("bp_in_ready", 64'(imm_ready), 64'h0);
        step(1'b0, 12'h789, 1'b1, 1'b0, 1'b0);
        chk_eq("bp_head", ext_q, 64'h123);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
        chk_eq("bp_second", ext_q, 64'h456);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
        chk_eq("bp_drained", 64'(ext_valid), 64'h0);

        // Reset with both entries full.
        step(1'b0, 12'hAAA, 1'b1, 1'b0, 1'b0);
        step(1'b0, 12'h555, 1'b1, 1'b0, 1'b0);
        step(1'b1, 12'h333, 1'b1, 1'b0, 1'b0);
        chk_eq("midrst_out_q", ext_q, 64'h0);
        chk_eq("midrst_valid", 64'(ext_valid), 64'h0);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 12'h0, 1'b0, 1'b1, 1'b0);

`ifdef ZE_9_SIGN_EXT_EN
        step(1'b0, 12'hFFF, 1'b1, 1'b1, 1'b1);
        chk_eq("sx_fff", ext_q, 64'hFFFFFFFFFFFFFFFF);
        step(1'b0, 12'h7FF, 1'b1, 1'b1, 1'b1);
        chk_eq("sx_7ff", ext_q, 64'h7FF);
        step(1'b0, 12'hFFF, 1'b1, 1'b1, 1'b0);
        chk_eq("zx_fff", ext_q, 64'hFFF);
`endif

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 63) == 0),
                 12'($urandom()),
                 ($urandom_range(0, 9) < 7),
                 ($urandom_range(0, 9) < 6),
                 1'($urandom()));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
